// File: rtl/pattern_sequencer_pkg.sv
// Shared types and constants for the imager pattern sequencer.
package patseq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FIRST = 3'd1;
  localparam state_t S_PATS  = 3'd2;
  localparam state_t S_WAIT  = 3'd3;
  localparam state_t S_LAST  = 3'd4;

  localparam logic [63:0] PAT_BLANK = '0;
  localparam logic [63:0] PAT_ALL1  = '1;

  function automatic int subframe_words(input int rows, input int wpr);
    return rows * wpr;
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Source-FIFO read side and imager-FIFO write side of the pattern sequencer.
interface pattern_sequencer_if #(parameter int PAT_W = 10);
  logic [PAT_W-1:0] pat_in;
  logic             pat_empty;
  logic             pat_rd_en;
  logic             dst_full;
  logic             dst_empty;
  logic             out_wr;
  logic [PAT_W-1:0] out_data;

  modport master (input pat_in, pat_empty, dst_full, dst_empty,
                  output pat_rd_en, out_wr, out_data);
  modport slave  (output pat_in, pat_empty, dst_full, dst_empty,
                  input pat_rd_en, out_wr, out_data);
endinterface

// File: rtl/pattern_word_ctr.sv
// Subframe word counter: saturates at MAX and flags terminal count.
module pattern_word_ctr #(
  parameter int MAX = 2880,
  parameter int W   = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;

  assign tc = (cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr)    cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pattern_sequencer.sv
// Streams first / N exposed / last subframe patterns into the imager FIFO.
// Macro PATSEQ_BLANK_EDGE_EN: first/last phases write blank words without popping the source.
module pattern_sequencer
  import patseq_pkg::*;
#(
  parameter int PAT_W         = 10,
  parameter int NUM_ROWS      = 160,
  parameter int WORDS_PER_ROW = 18,
  parameter int CNT_W         = 32,
  parameter int PAT_REVERSE   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cam_empty,
  input  logic             cam_full,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [CNT_W-1:0] cnt_subc,
  pattern_sequencer_if.master bus,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);
  localparam int SW   = subframe_words(NUM_ROWS, WORDS_PER_ROW);
  localparam int WC_W = $clog2(SW + 1);

  state_t           state, state_nx;
  logic             tc, wc_clr, fd_nx, urun_clr;
  logic             phase, need_src, wr_go, starve;
  logic [PAT_W-1:0] src_word, word;

  assign phase = (state == S_FIRST) || (state == S_PATS) || (state == S_LAST);
`ifdef PATSEQ_BLANK_EDGE_EN
  assign need_src = (state == S_PATS);
  assign word     = need_src ? src_word : PAT_BLANK[PAT_W-1:0];
`else
  assign need_src = phase;
  assign word     = src_word;
`endif

  // A phase writes once per cycle while room remains; only source-fed phases depend on pat_empty.
  assign wr_go         = phase && !tc && !bus.dst_full && (!need_src || !bus.pat_empty);
  assign bus.pat_rd_en = wr_go && need_src;
  assign starve        = need_src && !tc && bus.pat_empty;
  assign busy          = (state != S_IDLE);

  always_comb begin
    for (int i = 0; i < PAT_W; i++)
      src_word[i] = (PAT_REVERSE != 0) ? bus.pat_in[PAT_W-1-i] : bus.pat_in[i];
  end

  pattern_word_ctr #(.MAX(SW), .W(WC_W)) u_wcnt (
    .clk (clk),
    .rst (rst),
    .clr (wc_clr),
    .en  (wr_go),
    .tc  (tc)
  );

  always_comb begin
    state_nx = state;
    wc_clr   = 1'b0;
    fd_nx    = 1'b0;
    urun_clr = 1'b0;
    case (state)
      S_IDLE: if (start && cam_empty && !cam_full) begin
        state_nx = S_FIRST;
        wc_clr   = 1'b1;
        urun_clr = 1'b1;
      end
      S_FIRST: if (tc) begin
        wc_clr   = 1'b1;
        state_nx = (num_pat == '0) ? S_LAST : S_PATS;
      end
      S_PATS: if (tc) state_nx = S_WAIT;
      // Hold until the imager has drained the subframe before choosing the next phase.
      S_WAIT: if (bus.dst_empty && !bus.out_wr) begin
        wc_clr   = 1'b1;
        state_nx = (cnt_subc >= num_pat) ? S_LAST : S_PATS;
      end
      S_LAST: if (tc) begin
        state_nx = S_IDLE;
        fd_nx    = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      bus.out_wr   <= 1'b0;
      bus.out_data <= '0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state      <= state_nx;
      bus.out_wr <= wr_go;
      if (wr_go) bus.out_data <= word;
      frame_done <= fd_nx;
      if (urun_clr)    underrun <= 1'b0;
      else if (starve) underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer: source FIFO model, imager write checker, frame scenarios.
module tb_pattern_sequencer;
  import patseq_pkg::*;

  localparam int PAT_W = 10;
  localparam int CNT_W = 32;
  localparam int SW    = 2880;
`ifdef PATSEQ_BLANK_EDGE_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             cam_empty = 1'b1;
  logic             cam_full = 1'b0;
  logic [CNT_W-1:0] num_pat = '0;
  logic [CNT_W-1:0] cnt_subc = '0;
  logic             busy, frame_done, underrun;

  pattern_sequencer_if #(.PAT_W(PAT_W)) bus ();

  pattern_sequencer #(.PAT_W(PAT_W), .NUM_ROWS(160), .WORDS_PER_ROW(18),
                      .CNT_W(CNT_W), .PAT_REVERSE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cam_empty(cam_empty), .cam_full(cam_full),
    .num_pat(num_pat), .cnt_subc(cnt_subc), .bus(bus),
    .busy(busy), .frame_done(frame_done), .underrun(underrun));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [PAT_W-1:0] src_q[$];
  logic [PAT_W-1:0] exp_q[$];
  int nwr = 0, nfd = 0, nrd = 0, np_cur = 0, cyc = 0;
  bit hold_empty = 1'b0, bp_en = 1'b0, first_seen = 1'b0;
  logic [PAT_W-1:0] first_out = '0;

  function automatic int src_words(input int np);
    return BLANK ? np * SW : (np + 2) * SW;
  endfunction

  function automatic logic [PAT_W-1:0] rev(input logic [PAT_W-1:0] d);
    logic [PAT_W-1:0] r;
    for (int i = 0; i < PAT_W; i++) r[i] = d[PAT_W-1-i];
    return r;
  endfunction

  initial begin
    bus.pat_in    = '0;
    bus.pat_empty = 1'b1;
    bus.dst_full  = 1'b0;
    bus.dst_empty = 1'b1;
  end

  // Source FIFO / imager FIFO model: pops and scoreboard pushes use values seen at the edge.
  always @(posedge clk) begin
    bit pop_s, rst_s, is_blank;
    logic [PAT_W-1:0] din_s, e;
    pop_s = (bus.pat_rd_en === 1'b1);
    rst_s = rst;
    din_s = bus.pat_in;
    #1;
    cyc++;
    if (pop_s && src_q.size() > 0) begin
      void'(src_q.pop_front());
      nrd++;
      if (!rst_s) exp_q.push_back(rev(din_s));
    end
    if (bus.out_wr === 1'b1) begin
      if (!first_seen) begin first_seen = 1'b1; first_out = bus.out_data; end
      is_blank = BLANK && (nwr < SW || nwr >= (np_cur + 1) * SW);
      n_cmp++;
      if (is_blank) begin
        if (bus.out_data !== '0) begin
          n_err++; $display("FAIL blank_word idx=%0d got=%b want=0", nwr, bus.out_data);
        end
      end else if (exp_q.size() == 0) begin
        n_err++; $display("FAIL extra_write idx=%0d got=%b want=no write", nwr, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          n_err++; $display("FAIL data idx=%0d got=%b want=%b", nwr, bus.out_data, e);
        end
      end
      nwr++;
    end
    cnt_subc      = (nwr >= SW) ? CNT_W'((nwr - SW) / SW) : '0;
    bus.dst_full  = bp_en && (cyc % 3 == 0);
    bus.pat_in    = (src_q.size() > 0) ? src_q[0] : '0;
    bus.pat_empty = hold_empty || (src_q.size() == 0);
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) nfd++;
    if (bus.dst_full === 1'b1) begin
      n_cmp++;
      if (bus.pat_rd_en !== 1'b0) begin
        n_err++; $display("FAIL pop_while_full cyc=%0d got=%b want=0", cyc, bus.pat_rd_en);
      end
    end
  end

  task automatic load(input int n, input bit ones);
    for (int i = 0; i < n; i++) src_q.push_back(ones ? PAT_W'(1) : PAT_W'($urandom));
  endtask

  task automatic start_frame(input int np);
    @(posedge clk); #2;
    num_pat = CNT_W'(np); np_cur = np;
    nwr = 0; nfd = 0; nrd = 0; first_seen = 1'b0;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (nfd == 0 && k < budget) begin @(posedge clk); k++; end
    #2;
    n_cmp++;
    if (nfd == 0) begin n_err++; $display("FAIL %s_timeout got=no frame_done want=frame_done", name); end
  endtask

  task automatic check_frame(input string name, input int np, input bit urun);
    repeat (4) @(posedge clk);
    #2;
    n_cmp++;
    if (nwr != (np + 2) * SW) begin n_err++; $display("FAIL %s_writes got=%0d want=%0d", name, nwr, (np + 2) * SW); end
    n_cmp++;
    if (nrd != src_words(np)) begin n_err++; $display("FAIL %s_pops got=%0d want=%0d", name, nrd, src_words(np)); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL %s_leftover got=%0d want=0", name, exp_q.size()); end
    n_cmp++;
    if (nfd != 1) begin n_err++; $display("FAIL %s_frame_done got=%0d want=1", name, nfd); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy got=%b want=0", name, busy); end
    n_cmp++;
    if (underrun !== urun) begin n_err++; $display("FAIL %s_underrun got=%b want=%b", name, underrun, urun); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if ({busy, frame_done, underrun, bus.out_wr, bus.pat_rd_en} !== 5'b0 || bus.out_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b%b%b%b%b data=%b want=all 0",
               busy, frame_done, underrun, bus.out_wr, bus.pat_rd_en, bus.out_data);
    end
    rst = 1'b0;
    cam_empty = 1'b0;
    start = 1'b1; @(posedge clk); #2; start = 1'b0; @(posedge clk); #2;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL start_cam_not_empty got busy=%b want=0", busy); end
    cam_empty = 1'b1; cam_full = 1'b1;
    start = 1'b1; @(posedge clk); #2; start = 1'b0; @(posedge clk); #2;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL start_cam_full got busy=%b want=0", busy); end
    cam_full = 1'b0;
  endtask

  task automatic test_basic();
    load(src_words(2), 1'b0);
    start_frame(2);
    wait_done("basic", 20000);
    check_frame("basic", 2, 1'b0);
  endtask

  task automatic test_backpressure();
    bp_en = 1'b1;
    load(src_words(1), 1'b0);
    start_frame(1);
    wait_done("bp", 20000);
    bp_en = 1'b0;
    check_frame("bp", 1, 1'b0);
  endtask

  task automatic test_underrun();
    int stall_at, k;
    stall_at = BLANK ? SW + 100 : 100;
    load(stall_at - (BLANK ? SW : 0), 1'b0);
    start_frame(1);
    k = 0;
    while (nwr < stall_at && k < 10000) begin @(posedge clk); k++; end
    repeat (20) @(posedge clk);
    #2;
    n_cmp++;
    if (nwr != stall_at) begin n_err++; $display("FAIL underrun_stall got=%0d want=%0d", nwr, stall_at); end
    n_cmp++;
    if (underrun !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL underrun_flag got=%b busy=%b want=1 1", underrun, busy);
    end
    load(src_words(1) - (stall_at - (BLANK ? SW : 0)), 1'b0);
    wait_done("underrun", 20000);
    check_frame("underrun", 1, 1'b1);
  endtask

  task automatic test_zero_pat();
    load(src_words(0), 1'b0);
    start_frame(0);
    wait_done("zero", 10000);
    check_frame("zero", 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int k = 0;
    load(src_words(1), 1'b0);
    start_frame(1);
    while (nwr < SW + 1500 && k < 10000) begin @(posedge clk); k++; end
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    n_cmp++;
    if ({busy, bus.out_wr, bus.pat_rd_en, frame_done} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_mid got busy=%b wr=%b rd=%b fd=%b want=0 0 0 0",
               busy, bus.out_wr, bus.pat_rd_en, frame_done);
    end
    rst = 1'b0;
    src_q.delete();
    exp_q.delete();
    load(src_words(0), 1'b0);
    start_frame(0);
    wait_done("restart", 10000);
    check_frame("restart", 0, 1'b0);
  endtask

  task automatic test_reverse();
    logic [PAT_W-1:0] want;
    want = BLANK ? '0 : 10'b1000000000;
    load(src_words(0), 1'b1);
    start_frame(0);
    wait_done("reverse", 10000);
    n_cmp++;
    if (first_out !== want) begin n_err++; $display("FAIL reverse_first got=%b want=%b", first_out, want); end
    check_frame("reverse", 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_underrun();
    test_zero_pat();
    test_reset_mid();
    test_reverse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
